fpu_scoreboard: RTL
===================

Name: fpu_scoreboard

Overview:
Issue-side scheduler for the FP pipeline. Tracks in-flight FP register writes with per-register countdown counters and a writeback-slot shift register. Stalls decode on RAW, WAW and writeback-port conflicts. Sits between the FP decode/control logic, which supplies rd/rs1/rs2, use flags, reg_write and a latency class derived from the hazard bits, and the FP register file write port.

Parameters:
NREG, 32, number of FP registers; index width is 5 bits.
MAX_LAT, 4, maximum result latency in cycles; legal range 1..7, since the latency field is 3 bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
issue_valid  input  1  decoded FP op presented this cycle
issue_rd  input  5  destination FP register
issue_rs1  input  5  source 1 FP register
issue_rs2  input  5  source 2 FP register
use_rs1  input  1  op reads rs1
use_rs2  input  1  op reads rs2
reg_write  input  1  op writes an FP register
issue_lat  input  3  result latency L in cycles; decode sets L = 1 + is_hazard_0 + is_hazard_1 + is_hazard_2
stall  output  1  combinational; hold the op in decode
issue_fire  output  1  combinational; equals issue_valid & ~stall
wb_valid  output  1  registered; FP regfile write occurs this cycle
wb_rd  output  5  registered; register being written
fwd_rs1  output  1  combinational; rs1 must take the bypass path
fwd_rs2  output  1  combinational; rs2 must take the bypass path
idle  output  1  registered-derived; no write in flight

Behaviour:
- Reset is asynchronous, active-high. It clears all counters cnt[0..NREG-1] to 0 and all slots slot[1..MAX_LAT] to invalid. After reset: wb_valid=0, wb_rd=0, idle=1, stall=0 with issue_valid=0, fwd_rs*=0. Assertion mid-operation discards all in-flight state immediately; no writeback follows.
- Latency clamp: Le = 1 if issue_lat==0; Le = MAX_LAT if issue_lat>MAX_LAT; otherwise Le = issue_lat.
- Stall is the OR of three conditions, each evaluated only when issue_valid=1:
  - RAW: for each source with its use flag set, stall when cnt[rs] > T. T=0 without bypass; T=1 with bypass (see Optional Feature).
  - WAW: stall when reg_write and cnt[rd] > Le, so an older write can never land after a younger one.
  - Writeback port: stall when reg_write, Le < MAX_LAT, and slot[Le+1] is valid. The occupant would shift into slot[Le] in the same edge.
- Accept occurs at cycle t when issue_fire=1 and reg_write=1. At the t+1 edge: cnt[rd] <= Le and slot[Le] <= {valid, rd}.
- Every cycle, all nonzero counters decrement by 1 and slots shift down: slot[k] <= slot[k+1], and slot[MAX_LAT] is cleared unless loaded.
- Writeback is the registered slot[1]: wb_valid=slot[1].valid, wb_rd=slot[1].rd. An op accepted at cycle t writes back at cycle t+Le.
- Simultaneous events:
  - A new accept to rd overrides that cycle's decrement of cnt[rd].
  - A new slot load overrides the shift into that slot; the conflict check guarantees the shift source is empty.
- rd equal to rs1 or rs2 on the same op: source checks use the pre-update counter.
- reg_write=0 ops, e.g. FP-to-int: source checks still apply; no counter or slot is touched.
- issue_valid=0 forces stall=0 and fwd_rs*=0.
- idle=1 when all counters are 0 and all slots are invalid.
- Register 0 is an ordinary FP register with no special casing.

Optional Feature:
FPU_SCOREBOARD_BYPASS_EN.
- Defined: T=1. fwd_rs1 = issue_valid & use_rs1 & (cnt[rs1]==1), and likewise for rs2. The consumer issues in the writeback cycle and takes the result from the bypass mux.
- Undefined: T=0; fwd_rs1 and fwd_rs2 are tied 0. The consumer waits until the cycle after writeback, when cnt==0 and the regfile is read.

Test Plan:
1. Reset-and-issue: reset, then issue rd=3, L=1 at cycle 5 -> wb_valid=1 with wb_rd=3 at cycle 6, idle=0 in cycle 6, idle=1 in cycle 7.
2. RAW, L=2: fmul rd=5 at cycle 10, dependent use_rs1 rs1=5 presented from cycle 11.
   - Bypass off: stall at 11 and 12, fire at 13.
   - Bypass on: stall at 11, fire at 12 with fwd_rs1=1.
3. Writeback conflict: rd=1, L=2 fires at cycle 0; next cycle, L=1 op rd=2 -> stall=1 at cycle 1. It fires at cycle 2 with writebacks rd=1 at cycle 2 and rd=2 at cycle 3, one per cycle.
4. WAW: rd=7, L=4 fires; next cycle, rd=7, L=1 -> stalls while cnt[7]>1, fires when cnt[7]==1. Final wb order: the L=4 write first, then rd=7 from the L=1 op.
5. Clamp and no-write: issue_lat=0 -> behaves as L=1. issue_lat=7 with MAX_LAT=4 -> writeback 4 cycles later. reg_write=0 op -> no wb_valid and idle unchanged.
6. Async reset mid-flight: assert rst between clock edges with 3 ops in flight -> wb_valid, wb_rd and idle update immediately without a clock edge. No writeback follows, and a dependent op fires with no stall.

Source files
------------

// File: rtl/fpu_scoreboard.sv
// Issue-side FP scoreboard: per-register latency countdowns plus a writeback-slot shift register.
// Optional macro FPU_SCOREBOARD_BYPASS_EN lets a consumer issue in its producer's writeback cycle.
module fpu_scoreboard #(
  parameter int NREG    = 32,
  parameter int MAX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] issue_rd,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       reg_write,
  input  logic [2:0] issue_lat,
  output logic       stall,
  output logic       issue_fire,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       fwd_rs1,
  output logic       fwd_rs2,
  output logic       idle
);

  localparam logic [2:0] MAX_LAT_L = 3'(MAX_LAT);

`ifdef FPU_SCOREBOARD_BYPASS_EN
  localparam logic [2:0] RAW_T = 3'd1;
`else
  localparam logic [2:0] RAW_T = 3'd0;
`endif

  logic [NREG-1:0][2:0]      cnt;
  logic [NREG-1:0]           busy;
  logic [MAX_LAT+1:1]        slot_v;
  logic [MAX_LAT+1:1][4:0]   slot_rd;
  logic [2:0]                le;
  logic                      raw_hit;
  logic                      waw_hit;
  logic                      port_hit;
  logic                      accept;

  always_comb begin
    le = issue_lat;
    if (issue_lat == 3'd0) begin
      le = 3'd1;
    end else if (issue_lat > MAX_LAT_L) begin
      le = MAX_LAT_L;
    end
  end

  // Source/destination checks always see the counters before this cycle's update.
  assign raw_hit = (use_rs1 && (cnt[issue_rs1] > RAW_T)) ||
                   (use_rs2 && (cnt[issue_rs2] > RAW_T));
  assign waw_hit = reg_write && (cnt[issue_rd] > le);

  // slot[MAX_LAT+1] is a constant empty stage, so Le == MAX_LAT never conflicts.
  always_comb begin
    port_hit = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (le == 3'(k) && slot_v[k+1]) begin
        port_hit = reg_write;
      end
    end
  end

  assign stall      = issue_valid & (raw_hit | waw_hit | port_hit);
  assign issue_fire = issue_valid & ~stall;
  assign accept     = issue_fire & reg_write;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      logic [2:0] cnt_q;
      logic [2:0] cnt_d;

      always_comb begin
        cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        if (accept && issue_rd == 5'(gi)) begin
          cnt_d = le;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= 3'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt[gi]  = cnt_q;
      assign busy[gi] = (cnt_q != 3'd0);
    end

    for (gi = 1; gi <= MAX_LAT; gi++) begin : g_slot
      logic       v_q;
      logic       v_d;
      logic [4:0] rd_q;
      logic [4:0] rd_d;

      always_comb begin
        v_d  = slot_v[gi+1];
        rd_d = slot_rd[gi+1];
        if (accept && le == 3'(gi)) begin
          v_d  = 1'b1;
          rd_d = issue_rd;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q  <= 1'b0;
          rd_q <= 5'd0;
        end else begin
          v_q  <= v_d;
          rd_q <= rd_d;
        end
      end

      assign slot_v[gi]  = v_q;
      assign slot_rd[gi] = rd_q;
    end
  endgenerate

  assign slot_v[MAX_LAT+1]  = 1'b0;
  assign slot_rd[MAX_LAT+1] = 5'd0;

  assign wb_valid = slot_v[1];
  assign wb_rd    = slot_rd[1];
  assign idle     = ~(|busy) & ~(|slot_v[MAX_LAT:1]);

`ifdef FPU_SCOREBOARD_BYPASS_EN
  assign fwd_rs1 = issue_valid & use_rs1 & (cnt[issue_rs1] == 3'd1);
  assign fwd_rs2 = issue_valid & use_rs2 & (cnt[issue_rs2] == 3'd1);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

endmodule
